// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and parameter checks for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when the operand width splits evenly into whole chunks
  function automatic bit chunk_ok(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// rtl/rca_slice.sv - combinational CHUNK-bit ripple-carry adder slice
module rca_slice #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;
  assign co   = c[CHUNK];

  // One full-adder cell per bit, carry rippling from bit 0 upward
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder, CHUNK bits per clock, LSB chunk first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             carry_q;
  logic [IW-1:0]    k;
  logic             accept;
  logic [CHUNK-1:0] sl_x;
  logic [CHUNK-1:0] sl_y;
  logic [CHUNK-1:0] sl_s;
  logic             sl_co;

  // A new operation may only begin when nothing is in flight
  assign accept = start && (state != RUN);

  assign sl_x = a_r[k*CHUNK +: CHUNK];
  assign sl_y = b_r[k*CHUNK +: CHUNK];

  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (sl_x),
    .y  (sl_y),
    .ci (carry_r),
    .s  (sl_s),
    .co (sl_co)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: RUN lasts exactly NCHUNK cycles, DONE lasts one
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (k == LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: carry_r seeds with cin so chunk 0 absorbs the carry-in; the
  // visible carry is only written on the last chunk so it reads 0 until then
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      carry_q <= 1'b0;
      k       <= '0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      sum_r   <= '0;
      carry_r <= cin;
      carry_q <= 1'b0;
      k       <= '0;
    end else if (state == RUN) begin
      sum_r[k*CHUNK +: CHUNK] <= sl_s;
      carry_r                 <= sl_co;
      k                       <= k + 1'b1;
      if (k == LAST) carry_q <= sl_co;
    end
  end

  assign sum   = sum_r;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       st[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       ci[2];
  logic       busy_w[2];
  logic       done_w[2];
  logic       carry_w[2];
  logic [7:0] sum_w[2];

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum_w[0]), .carry(carry_w[0])
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(st[1]), .a(av[1]), .b(bv[1]), .cin(ci[1]),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum_w[1]), .carry(carry_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nchunk(input int u);
    return (u == 0) ? 8 : 2;
  endfunction

  // Called at a negedge: presents one operation, follows it to done and checks it.
  // Operands are scrambled right after the accepting edge to prove they were latched.
  task automatic run_op(input int u, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input bit hold, input bit disturb, input string tag);
    logic [8:0] ref9;
    int n, nb, nboth;
    bit seen;
    ref9 = {1'b0, x} + {1'b0, y} + {8'b0, c};
    st[u] = 1'b1; av[u] = x; bv[u] = y; ci[u] = c;
    n = 0; nb = 0; nboth = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (!hold) st[u] = 1'b0;
        av[u] = ~x; bv[u] = ~y; ci[u] = ~c;
      end
      if (disturb) begin
        if (n == 3) begin st[u] = 1'b1; av[u] = 8'h01; bv[u] = 8'h01; end
        if (n == 5) begin av[u] = 8'hF0; bv[u] = 8'h0F; end
        if (n == 6) st[u] = 1'b0;
      end
      if (busy_w[u] && done_w[u]) nboth++;
      if (busy_w[u]) nb++;
      if (done_w[u]) seen = 1'b1;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, n - 1, nchunk(u));
    chk({tag, " busy_cycles"}, nb, nchunk(u));
    chk({tag, " busy_and_done"}, nboth, 0);
    chk({tag, " sum"}, {24'b0, sum_w[u]}, {24'b0, ref9[7:0]});
    chk({tag, " carry"}, {31'b0, carry_w[u]}, {31'b0, ref9[8]});
  endtask

  // Counts done/busy over a quiet window to catch spurious operations
  task automatic quiet(input int u, input int cycles, input string tag);
    int nd, nb;
    nd = 0; nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_w[u]) nd++;
      if (busy_w[u]) nb++;
    end
    chk({tag, " extra_done"}, nd, 0);
    chk({tag, " extra_busy"}, nb, 0);
  endtask

  initial begin
    logic [7:0] blist[8];
    int n;
    blist = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h55, 8'hAA};
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      st[u] = 1'b0; av[u] = 8'hFF; bv[u] = 8'hFF; ci[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset busy", {31'b0, busy_w[u]}, 32'd0);
      chk("reset done", {31'b0, done_w[u]}, 32'd0);
      chk("reset sum", {24'b0, sum_w[u]}, 32'd0);
      chk("reset carry", {31'b0, carry_w[u]}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Basic vectors, CHUNK=1
    run_op(0, 8'h00, 8'h00, 1'b0, 0, 0, "c1 zero");
    @(negedge clk);
    run_op(0, 8'hFF, 8'h01, 1'b0, 0, 0, "c1 ff+01");
    @(negedge clk);
    run_op(0, 8'h5A, 8'hA5, 1'b1, 0, 0, "c1 5a+a5+1");
    chk("c1 hold sum", {24'b0, sum_w[0]}, 32'h00);
    @(negedge clk);
    chk("c1 hold sum idle", {24'b0, sum_w[0]}, 32'h00);
    chk("c1 hold carry idle", {31'b0, carry_w[0]}, 32'd1);

    // Basic vector, CHUNK=4
    run_op(1, 8'h3C, 8'h0F, 1'b0, 0, 0, "c4 3c+0f");
    @(negedge clk);

    // Start while busy is ignored and operand changes mid-RUN do nothing
    run_op(0, 8'h12, 8'h34, 1'b0, 0, 1, "c1 busy_restart");
    quiet(0, 12, "c1 busy_restart");
    chk("c1 busy_restart held_sum", {24'b0, sum_w[0]}, 32'h46);

    // Reset in the third RUN cycle abandons the operation
    st[0] = 1'b1; av[0] = 8'h77; bv[0] = 8'h11; ci[0] = 1'b0;
    n = 0;
    while (n < 3) begin
      @(negedge clk);
      n++;
      if (n == 1) st[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run busy", {31'b0, busy_w[0]}, 32'd0);
    chk("rst_run done", {31'b0, done_w[0]}, 32'd0);
    chk("rst_run sum", {24'b0, sum_w[0]}, 32'd0);
    chk("rst_run carry", {31'b0, carry_w[0]}, 32'd0);
    quiet(0, 12, "rst_run");
    run_op(0, 8'hC3, 8'h3D, 1'b1, 0, 0, "c1 after_rst");
    @(negedge clk);

    // Start held high: each op begins in the previous DONE cycle
    run_op(1, 8'h3C, 8'h0F, 1'b0, 1, 0, "c4 b2b0");
    run_op(1, 8'hFF, 8'hFF, 1'b1, 1, 0, "c4 b2b1");
    run_op(1, 8'h80, 8'h80, 1'b0, 1, 0, "c4 b2b2");
    run_op(1, 8'h12, 8'h34, 1'b1, 0, 0, "c4 b2b3");
    run_op(0, 8'hAA, 8'h56, 1'b0, 1, 0, "c1 b2b0");
    run_op(0, 8'h7F, 8'h00, 1'b1, 0, 0, "c1 b2b1");
    @(negedge clk);

    // Grid sweep for CHUNK=4 against a+b+cin, issued back to back
    for (int ia = 0; ia < 256; ia += 3) begin
      for (int ib = 0; ib < 8; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run_op(1, 8'(ia), blist[ib], ic[0], 1, 0, "c4 sweep");
        end
      end
    end
    st[1] = 1'b0;
    quiet(1, 3, "c4 sweep_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
